// File: rtl/cwru_transceiver_rx_deframer.sv
// Receive-side deframer: synchronizes the TX serial clock/data into CLK, finds
// byte alignment from the sync nibble, publishes the key mask and a 7-seg digit.
module cwru_transceiver_rx_deframer #(
  parameter logic [3:0]  SYNC_NIBBLE = 4'hA,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ser_clk_in,
  input  logic       ser_data_in,
  output logic [7:0] code_reg,
  output logic [3:0] key_mask,
  output logic       code_valid,
  output logic       locked,
  output logic [7:0] frame_err_cnt,
  output logic [6:0] HEX0
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state;
  logic              clk_s1, clk_s2, clk_s3;
  logic              data_s1, data_s2;
  logic [7:0]        shreg;
  logic [3:0]        bits_seen;
  logic [2:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic       edge_det;
  logic [7:0] post;
  logic [3:0] bits_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      clk_s1  <= ser_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ser_data_in;
      data_s2 <= data_s1;
    end
  end

  always_comb begin
    edge_det  = clk_s2 & ~clk_s3;
    post      = {shreg[6:0], data_s2};
    bits_next = (bits_seen == 4'd8) ? 4'd8 : bits_seen + 4'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= HUNT;
      shreg         <= '0;
      bits_seen     <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      code_reg      <= '0;
      key_mask      <= '0;
      code_valid    <= 1'b0;
      locked        <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      code_valid <= 1'b0;
      if (edge_det) begin
        idle_cnt  <= '0;
        shreg     <= post;
        bits_seen <= bits_next;
        case (state)
          HUNT: begin
            if (bits_next == 4'd8 && post[7:4] == SYNC_NIBBLE) begin
              code_reg   <= post;
              key_mask   <= post[3:0];
              code_valid <= 1'b1;
              state      <= LOCKED;
              locked     <= 1'b1;
              bit_cnt    <= '0;
            end
          end
          LOCKED: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (post[7:4] == SYNC_NIBBLE) begin
                code_reg   <= post;
                key_mask   <= post[3:0];
                code_valid <= 1'b1;
              end else begin
                // bits_seen stays saturated so HUNT can re-align on the next bit
                if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end else if (idle_cnt == IDLE_MAX) begin
        state     <= HUNT;
        locked    <= 1'b0;
        bits_seen <= '0;
        key_mask  <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_ONE;
      end
    end
  end

  always_comb begin
    HEX0 = 7'b1111111;
    if (key_mask[3])      HEX0 = 7'b0110000;
    else if (key_mask[2]) HEX0 = 7'b0100100;
    else if (key_mask[1]) HEX0 = 7'b1111001;
    else if (key_mask[0]) HEX0 = 7'b1000000;
  end

endmodule

// File: doc/cwru_transceiver_rx_deframer.md
# cwru_transceiver_rx_deframer

Receive-side deframer for the CWRU transceiver link. It sits directly downstream of the TX serializer, on the far end of the GPIO cable. It takes the serial bit clock and data that the TX drives out, synchronizes both into the local `CLK` domain and recovers 8-bit frame alignment from a sync nibble. It then publishes the received key mask and shows the highest pressed key number on a 7-segment digit.

## Interface
- `SYNC_NIBBLE`, 4'hA: required value of frame bits [7:4].
- `TIMEOUT`, 1024: number of `CLK` cycles with no `ser_clk_in` rising edge before the link is declared dead.
- `CLK`  input  1  system clock, 50 MHz.
- `RST`  input  1  reset, asynchronous, active-high.
- `ser_clk_in`  input  1  TX bit clock from GPIO; asynchronous to `CLK`.
- `ser_data_in`  input  1  TX serial data, MSB first; valid around the `ser_clk_in` rising edge.
- `code_reg`  output  8  last accepted frame.
- `key_mask`  output  4  active-high pressed-key mask, equal to `code_reg[3:0]` of the last accepted frame.
- `code_valid`  output  1  one-`CLK` pulse for each accepted frame.
- `locked`  output  1  frame alignment held.
- `frame_err_cnt`  output  8  count of sync failures while locked; saturates at 255.
- `HEX0`  output  7  active-low 7-segment digit, bit 6 = segment g, bit 0 = segment a.

## Operation
- **Input synchronization**
  - `ser_clk_in` and `ser_data_in` each pass through a 2-flop synchronizer.
  - A rising edge is detected on the synchronized clock against a third flop.
  - On each detected edge, shift the synchronized data into `shreg[7:0]`, LSB in.
  - `bits_seen` (4 bits) increments on each detected edge and saturates at 8.
- **State HUNT** (the reset state)
  - On a sampled bit, compute the post-shift value. If `bits_seen` is 8 (counting this bit) and post-shift `[7:4] == SYNC_NIBBLE`, accept the frame.
  - Then go to LOCKED with `bit_cnt` = 0.
- **State LOCKED**
  - `bit_cnt` (3 bits) increments on each sampled bit.
  - When it wraps 7→0, the 8th bit of the frame has arrived; check the post-shift value:
    - Match: accept the frame.
    - Mismatch: `frame_err_cnt` +1 (saturating), go to HUNT, no `code_valid`. `bits_seen` stays at 8, so HUNT may re-align on the very next bit.
- **Accept**
  - `code_reg` ← post-shift value and `key_mask` ← its `[3:0]`.
  - `code_valid` pulses for one cycle.
  - `locked` = 1 while in LOCKED.
- **Timeout**
  - `idle_cnt` counts `CLK` cycles since the last detected edge and resets to 0 on each edge.
  - When `idle_cnt` reaches `TIMEOUT`:
    - state → HUNT, `bits_seen` ← 0, `key_mask` ← 0.
    - `code_reg` and `frame_err_cnt` are held.
  - An edge in the same cycle wins: no timeout.
- **HEX0**, combinational from `key_mask`, showing the highest set bit:
  - bit 3 → "3" = 7'b0110000
  - bit 2 → "2" = 7'b0100100
  - bit 1 → "1" = 7'b1111001
  - bit 0 → "0" = 7'b1000000
  - mask 0 → blank = 7'b1111111

## Timing
- **Reset values:**
  - `code_reg` = 0, `key_mask` = 0, `code_valid` = 0, `locked` = 0, `frame_err_cnt` = 0, `HEX0` = 7'b1111111.
  - State = HUNT; `shreg`, `bits_seen`, `bit_cnt`, `idle_cnt` and all synchronizer flops = 0.
- **Latency:**
  - A `ser_clk_in` rising edge is sampled 3 `CLK` edges later (2 sync + 1 edge detect), together with the data synchronized in parallel.
  - `code_valid`, `code_reg`, `key_mask` and `locked` update on the `CLK` edge that samples the 8th bit.
  - `HEX0` follows `key_mask` in the same cycle.
- **Input requirement:** the `ser_clk_in` high and low phases are each at least 3 `CLK` periods, and data is stable for 3 `CLK` periods around the rising edge. A TX bit clock of `CLK`/8 or slower satisfies this.
- **Back-to-back frames:** `code_valid` pulses are exactly 8 bit periods apart; there are no gap bits.
- **Asynchronous reset mid-frame:** takes effect immediately and discards the partial frame. The first frame after release is aligned from HUNT.

## Test plan
- **Reset:** assert `RST` mid-run → all outputs at the listed reset values within the same cycle, `HEX0` = 7'b1111111.
- **Single frame:** 16 idle zero bits, then 0xA1 at `CLK`/8 → one `code_valid` pulse, `code_reg` = 0xA1, `key_mask` = 4'b0001, `HEX0` = 7'b1000000, `locked` = 1.
- **Back-to-back frames:** 0xA4 then 0xA9 → two pulses 64 `CLK` apart; final `key_mask` = 4'b1001, `HEX0` = 7'b0110000.
- **Sync failure:** while locked, send 0x51 → `frame_err_cnt` = 1, `locked` = 0, `code_reg` stays 0xA9. A following 0xA2 → `locked` = 1, `HEX0` = 7'b1111001.
- **Timeout:** stop `ser_clk_in` for `TIMEOUT`+10 cycles → `locked` = 0, `key_mask` = 0, `HEX0` blank, `code_reg` held.
- **Reset mid-frame:** pulse `RST` after 5 bits of 0xAC → state cleared. The next full 0xAC is accepted: `key_mask` = 4'b1100, `HEX0` = 7'b0110000.
